group13_sel_seq: RTL and testbench
==================================

GROUP13_SEL_SEQ -- requirements
Module: group13_sel_seq

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have parameter SCAN_PERIOD, default 50000: cycles between auto-scan advances.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ena  input  1  high = run; low = freeze FSM, timers and outputs.
REQ-006 SHALL have port btn_next  input  1  raw asynchronous pushbutton, advance to next slot.
REQ-007 SHALL have port btn_prev  input  1  raw asynchronous pushbutton, step to previous slot.
REQ-008 SHALL have port mode  input  1  0 = manual, 1 = auto-scan.
REQ-009 SHALL have port ext_sel  input  4  directly loaded slot index.
REQ-010 SHALL have port ext_load  input  1  single-cycle strobe that loads ext_sel.
REQ-011 SHALL have port slot_mask  input  16  bit i high = project slot i populated.
REQ-012 SHALL have port sel  output  4  registered slot index driving the group output mux select.
REQ-013 SHALL have port sel_valid  output  1  current sel points at a populated slot.
REQ-014 SHALL have port changed  output  1  one-cycle pulse when sel takes a new value.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer, then a debouncer per REQ-001; a debounced rising edge raises one request (next or prev).
REQ-016 SHALL discard both requests when next and prev rise in the same cycle.
REQ-017 SHALL, with mode=1, raise a next request every SCAN_PERIOD cycles; any button request or ext_load restarts the scan timer; the timer is held at 0 while mode=0.
REQ-018 SHALL implement FSM IDLE / SEARCH: IDLE + request -> SEARCH with cand = sel+1 or sel-1 (mod 16, wrapping 15->0 and 0->15) and step count 1.
REQ-019 SHALL, in SEARCH, each cycle: if cand is eligible (REQ-026), set sel=cand, pulse changed, go IDLE; else move cand one more step in the same direction.
REQ-020 SHALL, after 15 ineligible candidates, return to IDLE with sel unchanged and no changed pulse.
REQ-021 SHALL drop button and scan requests that arrive while in SEARCH.
REQ-022 SHALL give ext_load priority in any state: abort any search; if ext_sel is eligible, set sel=ext_sel on the next edge and pulse changed only when the value differs; if ineligible, ignore it; either way go IDLE.
REQ-023 SHALL drive sel_valid combinationally as slot_mask[sel].
REQ-024 SHALL, with ena=0, keep the synchronizers running and hold everything else; requests raised in that time are lost.

Reset
REQ-025 SHALL, on rst, asynchronously set sel=0, changed=0, FSM=IDLE, all counters 0 and debounced levels 0; sel_valid then follows slot_mask[0].

Configuration
REQ-026 SHALL, with macro GROUP13_SKIP_EMPTY_EN defined, treat a slot as eligible only when its slot_mask bit is 1.
REQ-027 SHALL, without GROUP13_SKIP_EMPTY_EN, treat every slot as eligible (SEARCH always finishes in one cycle), tie sel_valid to 1 and ignore slot_mask.

Structure
REQ-028 SHALL take from shared package group13_pkg: the FSM state enum, NUM_SLOTS=16 and SLOT_W=4.
REQ-029 SHALL put the synchronizer and debouncer in sub-module group13_debounce, instantiated once per button.

Verification
REQ-030 SHALL cover: DEBOUNCE_CYCLES=4, btn_next high for 3 cycles -> no change; held for 6 cycles -> sel 0->1 with one changed pulse.
REQ-031 SHALL cover: macro on, slot_mask=16'hFEFF, sel=7, next -> sel=9 (slot 8 skipped), 2 search cycles.
REQ-032 SHALL cover: sel=0, prev, mask all ones -> sel=15 (wrap).
REQ-033 SHALL cover: slot_mask=0, next -> sel unchanged after 15 search cycles, no changed pulse, sel_valid=0.
REQ-034 SHALL cover: mode=1, SCAN_PERIOD=20, mask all ones -> sel increments every 20 cycles, wraps 15->0; ext_load ext_sel=5 mid-search -> sel=5 next cycle and timer restarts.
REQ-035 SHALL cover: rst asserted mid-SEARCH -> sel=0, changed=0 immediately without a clock edge.

Source files
------------

// File: rtl/group13_pkg.sv
// group13_pkg: shared definitions for the group13 slot selector.
//   NUM_SLOTS / SLOT_W : slot count and index width.
//   state_e            : selector FSM states.
//   dir_e              : search direction.
//   step_slot()        : one step forward/backward, wrapping modulo NUM_SLOTS.
// Build option: GROUP13_SKIP_EMPTY_EN (used by group13_sel_seq).
package group13_pkg;
  localparam int NUM_SLOTS = 16;
  localparam int SLOT_W    = 4;

  typedef enum logic {ST_IDLE = 1'b0, ST_SEARCH = 1'b1} state_e;
  typedef enum logic {DIR_NEXT = 1'b0, DIR_PREV = 1'b1} dir_e;

  // SLOT_W-bit arithmetic gives the 15->0 / 0->15 wrap for free.
  function automatic logic [SLOT_W-1:0] step_slot(input logic [SLOT_W-1:0] idx,
                                                  input dir_e dir);
    return (dir == DIR_PREV) ? idx - SLOT_W'(1) : idx + SLOT_W'(1);
  endfunction
endpackage

// File: rtl/group13_debounce.sv
// group13_debounce: 2-flop synchronizer plus debouncer for one pushbutton.
//   clk, rst : clock, async active-high reset
//   ena      : low freezes the debouncer (synchronizer keeps running)
//   btn      : raw asynchronous button level
//   rise     : one-cycle pulse when a debounced 0->1 transition is accepted
// Build option: none.
module group13_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic btn,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          sync;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], btn};
  end
  assign sync = sync_q[1];

  // cnt_q counts consecutive cycles the synchronized input has disagreed
  // with the accepted level; the DEBOUNCE_CYCLES-th such cycle flips it.
  assign accept = (sync != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (ena) begin
      if (sync == level_q) begin
        cnt_d = '0;
      end else if (accept) begin
        level_d = sync;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise = ena & accept & sync;
endmodule

// File: rtl/group13_sel_seq.sv
// group13_sel_seq: slot selector driving the group output mux select.
//   clk, rst   : clock, async active-high reset
//   ena        : low freezes FSM, timers and outputs
//   btn_next/btn_prev : raw pushbuttons stepping forward/backward
//   mode       : 0 manual, 1 auto-scan every SCAN_PERIOD cycles
//   ext_sel/ext_load  : direct load of a slot index (highest priority)
//   slot_mask  : populated slots
//   sel, sel_valid, changed : registered select, populated flag, change pulse
// Build option: GROUP13_SKIP_EMPTY_EN -- when defined, searches and loads
// skip slots whose slot_mask bit is 0; otherwise every slot is eligible.
module group13_sel_seq
  import group13_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SCAN_PERIOD     = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic                 mode,
  input  logic [SLOT_W-1:0]    ext_sel,
  input  logic                 ext_load,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  output logic [SLOT_W-1:0]    sel,
  output logic                 sel_valid,
  output logic                 changed
);
  localparam int SCW       = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int MAX_STEPS = NUM_SLOTS - 1;

  logic              next_rise, prev_rise;
  logic              btn_req_next, btn_req_prev, restart, scan_req;
  logic              req_next, req_prev;
  logic              cand_ok, ext_ok;
  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [SLOT_W-1:0] cand_q, cand_d, step_q, step_d, sel_q, sel_d;
  logic              changed_q, changed_d;
  logic [SCW-1:0]    scan_q, scan_d;

  group13_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst(rst), .ena(ena), .btn(btn_next), .rise(next_rise));
  group13_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .rst(rst), .ena(ena), .btn(btn_prev), .rise(prev_rise));

  // Simultaneous next/prev edges cancel each other out entirely.
  assign btn_req_next = next_rise & ~prev_rise;
  assign btn_req_prev = prev_rise & ~next_rise;
  assign restart      = btn_req_next | btn_req_prev | ext_load;
  // A restart wins over a pending scan tick, so scan and button requests
  // are never raised together.
  assign scan_req     = mode & ~restart & (scan_q == SCW'(SCAN_PERIOD - 1));
  assign req_next     = btn_req_next | scan_req;
  assign req_prev     = btn_req_prev;

`ifdef GROUP13_SKIP_EMPTY_EN
  assign cand_ok   = slot_mask[cand_q];
  assign ext_ok    = slot_mask[ext_sel];
  assign sel_valid = slot_mask[sel_q];
`else
  assign cand_ok   = 1'b1;
  assign ext_ok    = 1'b1;
  // Constant 1; the mask term only keeps the port connected to logic.
  assign sel_valid = slot_mask[sel_q] | 1'b1;
`endif

  always_comb begin
    scan_d = scan_q;
    if (ena) begin
      if (!mode || restart || scan_q == SCW'(SCAN_PERIOD - 1)) scan_d = '0;
      else                                                   scan_d = scan_q + SCW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cand_d    = cand_q;
    step_d    = step_q;
    sel_d     = sel_q;
    changed_d = changed_q;
    if (ena) begin
      changed_d = 1'b0;
      if (ext_load) begin
        // Aborts any search; an ineligible index is simply ignored.
        state_d = ST_IDLE;
        if (ext_ok) begin
          sel_d     = ext_sel;
          changed_d = (ext_sel != sel_q);
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (req_next || req_prev) begin
              state_d = ST_SEARCH;
              dir_d   = req_prev ? DIR_PREV : DIR_NEXT;
              cand_d  = step_slot(sel_q, req_prev ? DIR_PREV : DIR_NEXT);
              step_d  = SLOT_W'(1);
            end
          end
          ST_SEARCH: begin
            // Requests arriving here are dropped by construction.
            if (cand_ok) begin
              sel_d     = cand_q;
              changed_d = 1'b1;
              state_d   = ST_IDLE;
            end else if (step_q == SLOT_W'(MAX_STEPS)) begin
              state_d = ST_IDLE;
            end else begin
              cand_d = step_slot(cand_q, dir_q);
              step_d = step_q + SLOT_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_NEXT;
      cand_q    <= '0;
      step_q    <= '0;
      sel_q     <= '0;
      changed_q <= 1'b0;
      scan_q    <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cand_q    <= cand_d;
      step_q    <= step_d;
      sel_q     <= sel_d;
      changed_q <= changed_d;
      scan_q    <= scan_d;
    end
  end

  assign sel     = sel_q;
  assign changed = changed_q;
endmodule

// File: tb/tb_group13_sel_seq.sv
// tb_group13_sel_seq: directed bench for group13_sel_seq with a scoreboard of
// expected sel values, popped on every changed pulse.
// Build option: GROUP13_SKIP_EMPTY_EN selects the empty-slot-skipping checks.
module tb_group13_sel_seq;
  import group13_pkg::*;

  localparam int DB = 4;
  localparam int SP = 20;

  logic        clk = 1'b0, rst = 1'b1, ena = 1'b1;
  logic        btn_next = 1'b0, btn_prev = 1'b0, mode = 1'b0, ext_load = 1'b0;
  logic [3:0]  ext_sel = 4'd0;
  logic [15:0] slot_mask = 16'hFFFF;
  logic [3:0]  sel;
  logic        sel_valid, changed;

  int n_chk = 0, n_fail = 0;
  int chg_cnt = 0, chg_cyc = 0, srch_cyc = 0, cyc = 0;
  logic [3:0] sb[$];

  group13_sel_seq #(.DEBOUNCE_CYCLES(DB), .SCAN_PERIOD(SP)) dut (
    .clk(clk), .rst(rst), .ena(ena), .btn_next(btn_next), .btn_prev(btn_prev),
    .mode(mode), .ext_sel(ext_sel), .ext_load(ext_load), .slot_mask(slot_mask),
    .sel(sel), .sel_valid(sel_valid), .changed(changed));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts search cycles and checks each changed pulse against the
  // scoreboard.
  always @(negedge clk) begin
    if (dut.state_q == ST_SEARCH) srch_cyc <= srch_cyc + 1;
    if (changed === 1'b1) begin
      chg_cnt <= chg_cnt + 1;
      chg_cyc <= cyc;
      chk("sb_pending_on_changed", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("sb_sel", 32'(sel), 32'(sb.pop_front()));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input bit nxt, input bit prv, input int n);
    btn_next = nxt; btn_prev = prv;
    tick(n);
    btn_next = 1'b0; btn_prev = 1'b0;
    tick(14);
  endtask

  task automatic load(input logic [3:0] v, input bit exp_chg);
    ext_sel = v; ext_load = 1'b1;
    if (exp_chg) sb.push_back(v);
    tick(1);
    ext_load = 1'b0;
    tick(2);
  endtask

  task automatic wait_chg(input int budget, output int at);
    int c0 = chg_cnt;
    int k  = 0;
    while (chg_cnt == c0 && k < budget) begin tick(1); k++; end
    chk("wait_chg_timeout", 32'(chg_cnt != c0), 1);
    at = chg_cyc;
  endtask

  task automatic wait_srch(input int budget);
    int k = 0;
    while (dut.state_q != ST_SEARCH && k < budget) begin tick(1); k++; end
    chk("wait_search_timeout", 32'(dut.state_q == ST_SEARCH), 1);
  endtask

  initial begin
    int c0, s0, t0, t1, t2, t3, t4;
    // Reset state
    #2;
    chk("rst_sel", sel, 0);
    chk("rst_changed", changed, 0);
    chk("rst_sel_valid", sel_valid, 1);
    tick(3); rst = 1'b0; tick(2);

    // Debounce: 3 cycles is too short, 6 is accepted once
    c0 = chg_cnt;
    press(1, 0, 3);
    chk("db_short_sel", sel, 0);
    chk("db_short_chg", c0 - chg_cnt, 0);
    sb.push_back(4'd1);
    s0 = srch_cyc;
    press(1, 0, 6);
    chk("db_long_sel", sel, 1);
    chk("db_long_chg", chg_cnt - c0, 1);
    chk("db_long_srch", srch_cyc - s0, 1);

    // Wrap both directions
    load(4'd0, 1'b1);
    sb.push_back(4'd15);
    press(0, 1, 6);
    chk("wrap_prev_sel", sel, 15);
    sb.push_back(4'd0);
    press(1, 0, 6);
    chk("wrap_next_sel", sel, 0);

    // Simultaneous next+prev is discarded
    c0 = chg_cnt;
    press(1, 1, 6);
    chk("both_sel", sel, 0);
    chk("both_chg", chg_cnt - c0, 0);

    // Loading the current value gives no pulse; a new value does
    load(4'd0, 1'b0);
    chk("load_same_chg", chg_cnt - c0, 0);
    load(4'd9, 1'b1);
    chk("load_new_sel", sel, 9);

    // ena=0 loses requests
    c0 = chg_cnt;
    ena = 1'b0;
    press(1, 0, 6);
    load(4'd3, 1'b0);
    ena = 1'b1;
    tick(4);
    chk("ena_sel", sel, 9);
    chk("ena_chg", chg_cnt - c0, 0);

`ifdef GROUP13_SKIP_EMPTY_EN
    load(4'd7, 1'b1);
    slot_mask = 16'hFEFF;
    sb.push_back(4'd9);
    s0 = srch_cyc;
    press(1, 0, 6);
    chk("skip_sel", sel, 9);
    chk("skip_srch", srch_cyc - s0, 2);
    chk("skip_valid", sel_valid, 1);
    slot_mask = 16'h0000;
    tick(1);
    chk("empty_valid", sel_valid, 0);
    c0 = chg_cnt;
    s0 = srch_cyc;
    press(1, 0, 6);
    tick(10);
    chk("empty_sel", sel, 9);
    chk("empty_chg", chg_cnt - c0, 0);
    chk("empty_srch", srch_cyc - s0, 15);
    load(4'd4, 1'b0);
    chk("empty_load_sel", sel, 9);
    slot_mask = 16'hFFFF;
`else
    slot_mask = 16'h0000;
    tick(1);
    chk("nomask_valid", sel_valid, 1);
    sb.push_back(4'd10);
    s0 = srch_cyc;
    press(1, 0, 6);
    chk("nomask_sel", sel, 10);
    chk("nomask_srch", srch_cyc - s0, 1);
    slot_mask = 16'hFFFF;
`endif

    // Auto-scan every SP cycles with wrap 15->0
    load(4'd14, 1'b1);
    sb.push_back(4'd15); sb.push_back(4'd0); sb.push_back(4'd1);
    mode = 1'b1;
    wait_chg(60, t0);
    chk("scan_first_sel", sel, 15);
    wait_chg(30, t1);
    chk("scan_period_a", t1 - t0, SP);
    wait_chg(30, t2);
    chk("scan_period_b", t2 - t1, SP);
    chk("scan_wrap_sel", sel, 1);

    // ext_load aborts a search; timer restarts from the load
    wait_srch(30);
    ext_sel = 4'd5; ext_load = 1'b1;
    sb.push_back(4'd5);
    tick(1);
    ext_load = 1'b0;
    chk("abort_sel", sel, 5);
    chk("abort_changed", changed, 1);
    tick(1);
    t3 = chg_cyc;
    sb.push_back(4'd6);
    wait_chg(40, t4);
    // SP timer cycles plus the one-cycle search
    chk("abort_restart", t4 - t3, SP + 1);
    mode = 1'b0;
    c0 = chg_cnt;
    tick(50);
    chk("manual_hold_chg", chg_cnt - c0, 0);
    chk("manual_hold_sel", sel, 6);

    // Async reset in the middle of a search
    mode = 1'b1;
    wait_srch(30);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", sel, 0);
    chk("async_rst_changed", changed, 0);
    tick(2);
    chk("rst_hold_sel", sel, 0);
    mode = 1'b0;
    rst = 1'b0;
    tick(3);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
